// File: rtl/tri_transform_engine.sv
// Triangle fetch and transform stage. It reads triangles from RAM, applies a 3x3 fixed-point
// matrix plus a translation to each vertex, and streams the results out over valid/ready.
module tri_transform_engine #(
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [ADDR_W-1:0]      base_addr_in,
    input  logic [ADDR_W-1:0]      tri_count_in,
    input  logic [9*COORD_W-1:0]   mat_in,
    input  logic [3*COORD_W-1:0]   trans_in,
    output logic [ADDR_W-1:0]      mem_addr_out,
    output logic                   mem_en_out,
    input  logic [9*COORD_W-1:0]   mem_data_in,
    output logic [9*COORD_W-1:0]   tri_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   last_out,
    output logic                   busy_out,
    output logic                   done_out
);

    // state   | meaning
    // S_IDLE  | waiting for start_in
    // S_FETCH | issue one RAM read for triangle idx
    // S_WAIT  | count down the RAM latency, capture data on the final cycle
    // S_XFORM | transform v0, v1, v2 on successive cycles
    // S_OUT   | present triangle until accepted
    // S_DONE  | one-cycle end-of-pass pulse

    localparam int VW    = 3 * COORD_W;
    localparam int TW    = 9 * COORD_W;
    localparam int ACC_W = 2 * COORD_W + 2;
    localparam int WC_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-COORD_W+1){1'b0}}, {(COORD_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-COORD_W+1){1'b1}}, {(COORD_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_XFORM,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q, count_q, idx_q;
    logic [TW-1:0]     mat_q, vtx_q, res_q;
    logic [VW-1:0]     trans_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [1:0]        vsel;
    logic              last_tri;

    logic [VW-1:0]                vin;
    logic [VW-1:0]                xform_vtx;
    logic signed [COORD_W-1:0]    m_s, v_s, t_s;
    logic signed [2*COORD_W-1:0]  prod;
    logic signed [ACC_W-1:0]      acc, shifted, sum;

    assign last_tri = (idx_q == (count_q - ADDR_W'(1)));

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_in) state_nxt = (tri_count_in == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_nxt = S_XFORM;
            S_XFORM: if (vsel == 2'd2) state_nxt = S_OUT;
            S_OUT:   if (ready_in) state_nxt = last_tri ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One vertex per cycle: three rows of three products, then floor-shift, translate, saturate.
    always_comb begin
        vin       = vtx_q[int'(vsel)*VW +: VW];
        xform_vtx = '0;
        m_s       = '0;
        v_s       = '0;
        t_s       = '0;
        prod      = '0;
        acc       = '0;
        shifted   = '0;
        sum       = '0;
        for (int i = 0; i < 3; i++) begin
            acc = '0;
            for (int j = 0; j < 3; j++) begin
                m_s  = mat_q[(3*i+j)*COORD_W +: COORD_W];
                v_s  = vin[j*COORD_W +: COORD_W];
                prod = m_s * v_s;
                acc  = acc + {{2{prod[2*COORD_W-1]}}, prod};
            end
            t_s     = trans_q[i*COORD_W +: COORD_W];
            shifted = acc >>> FRAC_W;
            sum     = shifted + {{(ACC_W-COORD_W){t_s[COORD_W-1]}}, t_s};
            if (sum > SAT_MAX)
                xform_vtx[i*COORD_W +: COORD_W] = SAT_MAX[COORD_W-1:0];
            else if (sum < SAT_MIN)
                xform_vtx[i*COORD_W +: COORD_W] = SAT_MIN[COORD_W-1:0];
            else
                xform_vtx[i*COORD_W +: COORD_W] = sum[COORD_W-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            base_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            mat_q    <= '0;
            trans_q  <= '0;
            vtx_q    <= '0;
            res_q    <= '0;
            wait_cnt <= '0;
            vsel     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        base_q  <= base_addr_in;
                        count_q <= tri_count_in;
                        mat_q   <= mat_in;
                        trans_q <= trans_in;
                        idx_q   <= '0;
                    end
                end
                S_FETCH: wait_cnt <= WC_W'(MEM_LAT - 1);
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        vtx_q <= mem_data_in;
                        vsel  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WC_W'(1);
                    end
                end
                S_XFORM: begin
                    res_q[int'(vsel)*VW +: VW] <= xform_vtx;
                    vsel <= vsel + 2'd1;
                end
                S_OUT: if (ready_in && !last_tri) idx_q <= idx_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign mem_addr_out = base_q + idx_q;
    assign mem_en_out   = (state == S_FETCH);
    assign tri_out      = res_q;
    assign valid_out    = (state == S_OUT);
    assign last_out     = (state == S_OUT) && last_tri;
    assign busy_out     = (state != S_IDLE);
    assign done_out     = (state == S_DONE);

endmodule

// File: tb/tb_tri_transform_engine.sv
// Directed bench for tri_transform_engine: a RAM model feeds the DUT, and a scoreboard queue
// holds expected triangles and fetch addresses that are checked against what the DUT produces.
module tb_tri_transform_engine;
    localparam int W  = 16;
    localparam int AW = 12;
    localparam int ML = 2;
    localparam int TW = 9 * W;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic [AW-1:0] base_addr_in = '0;
    logic [AW-1:0] tri_count_in = '0;
    logic [TW-1:0] mat_in = '0;
    logic [3*W-1:0] trans_in = '0;
    logic [AW-1:0] mem_addr_out;
    logic          mem_en_out;
    logic [TW-1:0] mem_data_in;
    logic [TW-1:0] tri_out;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic          last_out;
    logic          busy_out;
    logic          done_out;

    always #5 clk = ~clk;

    tri_transform_engine #(.COORD_W(W), .FRAC_W(8), .ADDR_W(AW), .MEM_LAT(ML)) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .base_addr_in(base_addr_in),
        .tri_count_in(tri_count_in), .mat_in(mat_in), .trans_in(trans_in),
        .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_data_in(mem_data_in),
        .tri_out(tri_out), .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    // Two-stage read pipeline: data appears MEM_LAT edges after the strobe.
    logic [TW-1:0] ram [0:4095];
    logic [TW-1:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        if (mem_en_out) p1 <= ram[mem_addr_out];
        p2 <= p1;
    end
    assign mem_data_in = p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    logic [TW-1:0] exp_q [$];
    bit            last_q [$];
    logic [AW-1:0] addr_q [$];

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*W-1:0] vtx(input int x, input int y, input int z);
        logic [W-1:0] xs, ys, zs;
        xs = W'(x); ys = W'(y); zs = W'(z);
        return {zs, ys, xs};
    endfunction

    function automatic logic [TW-1:0] diag(input logic [W-1:0] d);
        return {d, 16'h0, 16'h0, 16'h0, d, 16'h0, 16'h0, 16'h0, d};
    endfunction

    function automatic logic [TW-1:0] model(input logic [TW-1:0] word, input logic [TW-1:0] mat,
                                            input logic [3*W-1:0] trans);
        logic [TW-1:0] r;
        logic signed [W-1:0] ms, vs, ts;
        longint acc, res;
        r = '0;
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 3; i++) begin
                acc = 0;
                for (int j = 0; j < 3; j++) begin
                    ms = mat[(3*i+j)*W +: W];
                    vs = word[(3*v+j)*W +: W];
                    acc += longint'(ms) * longint'(vs);
                end
                ts  = trans[i*W +: W];
                res = (acc >>> 8) + longint'(ts);
                if (res > 32767) res = 32767;
                if (res < -32768) res = -32768;
                r[(3*v+i)*W +: W] = W'(res);
            end
        return r;
    endfunction

    // mode: 0 model, 1 expect RAM word unchanged, 2 expect lit (single triangle)
    task automatic run_pass(input string tag, input logic [AW-1:0] base, input int count,
                            input logic [TW-1:0] mat, input logic [3*W-1:0] trans,
                            input int hold, input int mode, input logic [TW-1:0] lit);
        int t0, hs, dn, budget;
        bit fin, seen;
        logic [TW-1:0] held, e;
        logic [AW-1:0] a;
        for (int k = 0; k < count; k++) begin
            a = base + AW'(k);
            addr_q.push_back(a);
            e = (mode == 0) ? model(ram[a], mat, trans) : (mode == 1) ? ram[a] : lit;
            exp_q.push_back(e);
            last_q.push_back(k == count - 1);
        end
        @(negedge clk);
        base_addr_in = base; tri_count_in = AW'(count); mat_in = mat; trans_in = trans;
        start_in = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_in = 1'b0;
        mat_in = '1; trans_in = '1; base_addr_in = 12'h555; tri_count_in = 12'h7;
        hs = 0; dn = 0; fin = 0; seen = 0;
        budget = count * (ML + 5) + hold + 20;
        for (int c = 0; c < budget && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_en_out) begin
                if (addr_q.size() == 0) chk({tag, " extra_fetch"}, 1, 0);
                else chk({tag, " fetch_addr"}, mem_addr_out, addr_q.pop_front());
            end
            if (valid_out && !seen) begin
                seen = 1;
                chk({tag, " first_valid_cycle"}, cyc, t0 + 5 + ML);
                if (hold > 0) begin
                    ready_in = 1'b0;
                    held = tri_out;
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        chk({tag, " hold_valid"}, valid_out, 1);
                        chk({tag, " hold_tri"}, tri_out, held);
                        chk({tag, " hold_no_fetch"}, mem_en_out, 0);
                    end
                    ready_in = 1'b1;
                end
            end
            if (valid_out && ready_in) begin
                hs++;
                if (exp_q.size() == 0) chk({tag, " extra_valid"}, 1, 0);
                else begin
                    chk({tag, " tri"}, tri_out, exp_q.pop_front());
                    chk({tag, " last"}, last_out, last_q.pop_front());
                end
            end
            if (done_out) begin
                dn++;
                fin = 1;
                if (count == 0) chk({tag, " done_cycle"}, cyc, t0 + 1);
            end
        end
        chk({tag, " finished"}, fin, 1);
        chk({tag, " handshakes"}, hs, count);
        chk({tag, " addr_left"}, addr_q.size(), 0);
        @(negedge clk);
        chk({tag, " done_single"}, done_out, 0);
        chk({tag, " idle_after"}, busy_out, 0);
        exp_q.delete(); last_q.delete(); addr_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " valid"}, valid_out, 0);
        chk({tag, " busy"}, busy_out, 0);
        chk({tag, " done"}, done_out, 0);
        chk({tag, " mem_en"}, mem_en_out, 0);
        chk({tag, " last"}, last_out, 0);
        chk({tag, " tri"}, tri_out, 0);
        chk({tag, " mem_addr"}, mem_addr_out, 0);
    endtask

    initial begin
        logic [159:0] rnd;
        logic [TW-1:0] rmat, rot;
        int t0;
        for (int a = 0; a < 4096; a++) ram[a] = '0;
        for (int k = 0; k < 8; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            ram[12'h010 + k] = rnd[TW-1:0];
        end
        ram[12'h100] = {vtx(100, 50, -20), vtx(1, -1, 7), vtx(100, 50, -20)};
        ram[12'h101] = {vtx(3, 4, 5), vtx(-7, 2, 0), vtx(3, 4, 5)};
        ram[12'h102] = {vtx(4000, -4000, 0), vtx(-4000, 4000, 1), vtx(4000, -4000, 0)};
        ram[12'hFFF] = {vtx(9, 8, 7), vtx(6, 5, 4), vtx(3, 2, 1)};
        ram[12'h000] = {vtx(-9, -8, -7), vtx(-6, -5, -4), vtx(-3, -2, -1)};

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_in = 1'b0;

        run_pass("identity", 12'h010, 4, diag(16'h0100), '0, 0, 1, '0);

        run_pass("scale2", 12'h100, 1, diag(16'h0200), {16'd0, -16'sd5, 16'd10}, 0, 2,
                 {vtx(210, 95, -40), vtx(12, -7, 14), vtx(210, 95, -40)});

        rot = {16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100,
               16'h0000, 16'hFF00, 16'h0000};
        run_pass("rotz", 12'h101, 1, rot, '0, 0, 2,
                 {vtx(-4, 3, 5), vtx(-2, -7, 0), vtx(-4, 3, 5)});

        run_pass("saturate", 12'h102, 1, diag(16'h1000), '0, 0, 2,
                 {vtx(32767, -32768, 0), vtx(-32768, 32767, 16), vtx(32767, -32768, 0)});

        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rmat = rnd[TW-1:0];
        run_pass("stall", 12'h014, 2, rmat, 48'h0123_FF80_7FFF, 10, 0, '0);

        run_pass("count0", 12'h020, 0, diag(16'h0100), '0, 0, 0, '0);

        run_pass("wrap", 12'hFFF, 2, diag(16'h0100), {16'd1, 16'd2, 16'd3}, 0, 0, '0);

        @(negedge clk);
        base_addr_in = 12'h010; tri_count_in = 12'd3; mat_in = diag(16'h0100); trans_in = '0;
        start_in = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_in = 1'b0;
        for (int c = 0; c < 10 && cyc < t0 + 4; c++) @(negedge clk);
        chk("abort in_xform_busy", busy_out, 1);
        rst_in = 1'b1;
        @(negedge clk);
        chk_outputs_zero("abort");
        rst_in = 1'b0;
        run_pass("after_abort", 12'h011, 2, diag(16'h0100), '0, 0, 1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
